// File: rtl/updown_cntr_pkg.sv
// Shared encodings for the up/down counter sequencer: command opcodes and FSM states.
package updown_cntr_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_GOTO = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/updown_cntr_seq.sv
// Command sequencer for a WIDTH-bit up/down counter (LOAD / UP n / DOWN n / GOTO target).
// Define UPDOWN_CNTR_SAT_EN to stop runs at the counter limits and flag them with sat.
module updown_cntr_seq
   import updown_cntr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_val,
   output logic             cnt_ld,
   output logic [WIDTH-1:0] cnt_ld_val,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             busy,
   output logic             done,
   output logic             sat
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] ld_val_q, ld_val_d;
   logic             dir_q, dir_d;
   logic             sat_q, sat_d;
   logic             accept;
   logic             in_run;
   logic             at_limit;

   assign cmd_ready = (state_q == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign in_run    = (state_q == S_RUN);

`ifdef UPDOWN_CNTR_SAT_EN
   assign at_limit = dir_q ? (cnt_val == CNT_MAX) : (cnt_val == '0);
`else
   assign at_limit = 1'b0;
`endif

   // A reset cycle must never move the counter, even mid-run.
   assign cnt_en     = in_run && (rem_q != '0) && !abort && !at_limit && !rst;
   assign cnt_up     = in_run && dir_q;
   assign cnt_ld     = (state_q == S_LOAD) && !rst;
   assign cnt_ld_val = ld_val_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign sat        = done && sat_q;

   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch behind.
      state_d  = state_q;
      rem_d    = rem_q;
      ld_val_d = ld_val_q;
      dir_d    = dir_q;
      sat_d    = sat_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_LOAD: begin
                     state_d  = S_LOAD;
                     ld_val_d = cmd_arg;
                  end
                  OP_UP: begin
                     state_d = S_RUN;
                     rem_d   = cmd_arg;
                     dir_d   = 1'b1;
                  end
                  OP_DOWN: begin
                     state_d = S_RUN;
                     rem_d   = cmd_arg;
                     dir_d   = 1'b0;
                  end
                  default: begin
                     state_d = S_RUN;
                     dir_d   = (cmd_arg >= cnt_val);
                     rem_d   = (cmd_arg >= cnt_val) ? (cmd_arg - cnt_val) : (cnt_val - cmd_arg);
                  end
               endcase
            end
         end
         S_LOAD: state_d = S_DONE;
         S_RUN: begin
            // Completion takes priority over abort and limit so a finished run never reports sat.
            if (rem_q == '0) begin
               state_d = S_DONE;
            end else if (abort) begin
               state_d = S_DONE;
               rem_d   = '0;
            end else if (at_limit) begin
               state_d = S_DONE;
               rem_d   = '0;
               sat_d   = 1'b1;
            end else begin
               rem_d = rem_q - WIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            sat_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      if (rst) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         ld_val_q <= '0;
         dir_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         ld_val_q <= ld_val_d;
         dir_q    <= dir_d;
         sat_q    <= sat_d;
      end
   end

endmodule

// File: tb/tb_updown_cntr_seq.sv
// Self-checking bench for updown_cntr_seq driving a simple 4-bit up/down counter.
// Build with UPDOWN_CNTR_SAT_EN defined to exercise the saturating variant.
module tb_updown_cntr_seq;
   import updown_cntr_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_arg;
   logic       abort;
   logic [3:0] cnt_val;
   logic       cnt_ld;
   logic [3:0] cnt_ld_val;
   logic       cnt_en;
   logic       cnt_up;
   logic       busy;
   logic       done;
   logic       sat;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   updown_cntr_seq #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .cnt_val(cnt_val),
      .cnt_ld(cnt_ld), .cnt_ld_val(cnt_ld_val), .cnt_en(cnt_en), .cnt_up(cnt_up),
      .busy(busy), .done(done), .sat(sat)
   );

   // The counter being sequenced.
   always_ff @(posedge clk) begin
      if (rst)         cnt_val <= 4'd0;
      else if (cnt_ld) cnt_val <= cnt_ld_val;
      else if (cnt_en) cnt_val <= cnt_up ? cnt_val + 4'd1 : cnt_val - 4'd1;
   end

   typedef struct {
      logic [1:0] op;
      logic [3:0] arg;
      int         abort_at;
      int         steps;
      int         ups;
      int         lat;
      int         final_v;
      int         sat;
      int         lds;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: outcome of one command from start value v, from the command rules alone.
   function automatic void model(input int op, input int arg, input int v,
                                 output int st, output int up, output int sa, output int fin);
      int room;
      st = 0; up = 0; sa = 0; fin = v;
      if (op == 0) begin
         fin = arg;
      end else if (op == 3) begin
         up  = (arg >= v) ? 1 : 0;
         st  = up ? arg - v : v - arg;
         fin = arg;
      end else begin
         up = (op == 1) ? 1 : 0;
`ifdef UPDOWN_CNTR_SAT_EN
         room = up ? 15 - v : v;
         st   = (arg <= room) ? arg : room;
         sa   = (arg > room) ? 1 : 0;
`else
         room = 0;
         st   = arg;
`endif
         fin = (up ? v + st : v - st + 16) % 16;
      end
   endfunction

   // Issues one command and observes it until done; entered and left just after a falling edge.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg, input int abort_at,
                          output int steps, output int ups, output int lat, output int sat_seen,
                          output int lds, output int ld_bad, output int rdy_done);
      int c;
      int guard;
      steps = 0; ups = 0; lat = -1; sat_seen = 0; lds = 0; ld_bad = 0; rdy_done = -1;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(negedge clk); #1;
         guard++;
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      c = 1;
      while (c <= 40) begin
         abort = (c == abort_at);
         #1;
         if (cnt_en) begin
            steps++;
            if (cnt_up) ups++;
         end
         if (cnt_ld) begin
            lds++;
            if (cnt_ld_val != arg) ld_bad++;
         end
         if (done) begin
            lat = c; sat_seen = sat; rdy_done = cmd_ready;
            break;
         end
         @(negedge clk);
         c++;
      end
      abort = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic check_cmd(input string tag, input vec_t v);
      int steps, ups, lat, sat_seen, lds, ld_bad, rdy_done;
      run_cmd(v.op, v.arg, v.abort_at, steps, ups, lat, sat_seen, lds, ld_bad, rdy_done);
      check({tag, " steps"},     steps,   v.steps);
      check({tag, " up_steps"},  ups,     v.ups);
      check({tag, " latency"},   lat,     v.lat);
      check({tag, " sat"},       sat_seen, v.sat);
      check({tag, " loads"},     lds,     v.lds);
      check({tag, " ld_val"},    ld_bad,  0);
      check({tag, " final"},     int'(cnt_val), v.final_v);
      check({tag, " rdy_done"},  rdy_done, 0);
      check({tag, " rdy_after"}, int'(cmd_ready), 1);
   endtask

   initial begin
      int model_v;
      int st, up, sa, fin, ab;
      vec_t rv;
      int done_cnt, en_cnt;

      vecs[0] = '{OP_LOAD, 4'd9,  0, 0,  0,  2,  9, 0, 1};
      vecs[1] = '{OP_UP,   4'd5,  0, 5,  5,  7, 14, 0, 0};
      vecs[2] = '{OP_DOWN, 4'd0,  1, 0,  0,  2, 14, 0, 0};
      vecs[3] = '{OP_GOTO, 4'd3,  0, 11, 0, 13,  3, 0, 0};
      vecs[4] = '{OP_GOTO, 4'd3,  0, 0,  0,  2,  3, 0, 0};
      vecs[5] = '{OP_LOAD, 4'd14, 0, 0,  0,  2, 14, 0, 1};
`ifdef UPDOWN_CNTR_SAT_EN
      vecs[6] = '{OP_UP,   4'd4,  0, 1,  1,  3, 15, 1, 0};
`else
      vecs[6] = '{OP_UP,   4'd4,  0, 4,  4,  6,  2, 0, 0};
`endif
      vecs[7] = '{OP_LOAD, 4'd0,  0, 0,  0,  2,  0, 0, 1};
      vecs[8] = '{OP_UP,   4'd10, 3, 2,  2,  4,  2, 0, 0};
`ifdef UPDOWN_CNTR_SAT_EN
      vecs[9] = '{OP_DOWN, 4'd3,  0, 2,  0,  4,  0, 1, 0};
`else
      vecs[9] = '{OP_DOWN, 4'd3,  0, 3,  0,  5, 15, 0, 0};
`endif

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'd0; abort = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      check("rst ready_low", int'(cmd_ready), 0);
      check("rst en_low",    int'(cnt_en), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset ready",  int'(cmd_ready), 1);
      check("reset busy",   int'(busy), 0);
      check("reset done",   int'(done), 0);
      check("reset sat",    int'(sat), 0);
      check("reset ld",     int'(cnt_ld), 0);
      check("reset ld_val", int'(cnt_ld_val), 0);
      check("reset en",     int'(cnt_en), 0);
      check("reset up",     int'(cnt_up), 0);

      foreach (vecs[i]) check_cmd($sformatf("vec%0d", i), vecs[i]);
      model_v = vecs[9].final_v;

      for (int n = 0; n < 40; n++) begin
         rv.op  = 2'($urandom_range(0, 3));
         rv.arg = 4'($urandom_range(0, 15));
         model(int'(rv.op), int'(rv.arg), model_v, st, up, sa, fin);
         ab = 0;
         if (st > 0 && $urandom_range(0, 3) == 0) begin
            ab  = $urandom_range(1, st);
            st  = ab - 1;
            sa  = 0;
            fin = (up ? model_v + st : model_v - st + 16) % 16;
         end
         rv.abort_at = ab;
         rv.steps    = st;
         rv.ups      = up ? st : 0;
         rv.lat      = (ab != 0) ? ab + 1 : st + 2;
         rv.final_v  = fin;
         rv.sat      = sa;
         rv.lds      = (rv.op == OP_LOAD) ? 1 : 0;
         check_cmd($sformatf("rnd%0d", n), rv);
         model_v = fin;
      end

      // Reset in the middle of a run: stepping stops at once and no done follows.
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 4'd8;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("midrst en_c1", int'(cnt_en), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst en_in_rst", int'(cnt_en), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst busy",  int'(busy), 0);
      check("midrst ready", int'(cmd_ready), 1);
      check("midrst cnt",   int'(cnt_val), 0);
      done_cnt = 0; en_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (done) done_cnt++;
         if (cnt_en) en_cnt++;
         @(negedge clk); #1;
      end
      check("midrst no_done", done_cnt, 0);
      check("midrst no_en",   en_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
